aes_inv_cipher_iter: RTL

//  Iterative AES inverse cipher: one ciphertext block in, one plaintext block out, one round per clock.

---
 rtl/aes_inv_cipher_iter_pkg.sv | 69 ++++++
 rtl/aes_inv_cipher_iter_sbox.sv | 31 +++
 rtl/aes_inv_cipher_iter.sv | 100 ++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared AES decrypt helpers: byte/state types, GF(2^8) arithmetic and the
// linear round steps (InvShiftRows, InvMixColumns) used by the iterative core.
// Byte k of a state lives at bits [127-8k -: 8]; row = k%4, col = k/4.
package aes_inv_cipher_iter_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  // Reduction term of the AES field polynomial x^8+x^4+x^3+x+1 (0x11B).
  localparam byte_t AES_POLY = 8'h1B;

  // Multiply by x in GF(2^8).
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // General GF(2^8) multiply; with a constant operand this folds to a few XORs.
  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // LSB position of byte k inside a 128-bit state (8*(15-k)).
  function automatic logic [6:0] byte_lsb(input logic [3:0] k);
    return {~k, 3'b000};
  endfunction

  // Row r rotates right by r columns: out(r,c) = in(r,(c-r) mod 4).
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    int     r;
    int     c;
    int     src;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      r   = k % 4;
      c   = k / 4;
      src = 4 * ((c - r) & 3) + r;
      o[byte_lsb(4'(k)) +: 8] = s[byte_lsb(4'(src)) +: 8];
    end
    return o;
  endfunction

  // Column-wise multiply by the circulant matrix {0e 0b 0d 09}.
  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    byte_t  a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[byte_lsb(4'(4*c))   +: 8];
      a1 = s[byte_lsb(4'(4*c+1)) +: 8];
      a2 = s[byte_lsb(4'(4*c+2)) +: 8];
      a3 = s[byte_lsb(4'(4*c+3)) +: 8];
      o[byte_lsb(4'(4*c))   +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[byte_lsb(4'(4*c+1)) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[byte_lsb(4'(4*c+2)) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[byte_lsb(4'(4*c+3)) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_sbox.sv
// AES inverse S-box: 8-bit combinational lookup table.
module aes_inv_cipher_iter_sbox
  import aes_inv_cipher_iter_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Pure table lookup, no state.
  always_comb o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock on a single shared round
// datapath, round keys fetched from an external key store via rk_idx.
// Flow per block: IDLE (initial AddRoundKey with key NR) -> NR-1 full rounds
// -> final round without InvMixColumns -> DONE (hold until sink accepts).
module aes_inv_cipher_iter
  import aes_inv_cipher_iter_pkg::*;
#(
  parameter int NR = 10
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Key index for the initial AddRoundKey and the counter value after it.
  localparam logic [3:0] NR_IDX    = 4'(NR);
  localparam logic [3:0] CNT_START = 4'(NR - 1);

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  state_t     r_data;

  state_t     w_isr;
  state_t     w_isb;
  state_t     w_addkey;
  state_t     w_imc;

  // Shared round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
  // The final round takes the tap before InvMixColumns.
  assign w_isr = inv_shift_rows(r_data);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_cipher_iter_sbox u_sbox (
      .i_byte (w_isr[8*g +: 8]),
      .o_byte (w_isb[8*g +: 8])
    );
  end

  assign w_addkey = w_isb ^ rk;
  assign w_imc    = inv_mix_columns(w_addkey);

  // Round-key address is a pure function of state so the key store can answer in-cycle.
  always_comb begin
    rk_idx = 4'd0;
    case (r_state)
      ST_IDLE:  rk_idx = NR_IDX;
      ST_ROUND: rk_idx = r_cnt;
      default:  rk_idx = 4'd0;
    endcase
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out       = r_data;

  // Control FSM, round counter and the state register; reset abandons any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data  <= in ^ rk;
            r_cnt   <= CNT_START;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (r_cnt != 4'd0) begin
            r_data <= w_imc;
            r_cnt  <= r_cnt - 4'd1;
          end else begin
            r_data  <= w_addkey;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // r_data is left untouched so the output stays stable under back-pressure.
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
